// File: rtl/wb_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_arb_pkg - shared types for the register-file write-port arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package wb_arb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_pend_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_STALL = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_pend_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pend_fifo - pending MDU result buffer with squash-by-rd           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_pend_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [REG_ADDR_W-1:0]             push_rd,
  input  logic [XLEN-1:0]                   push_data,
  input  logic                              pop,
  input  logic                              squash_en,
  input  logic [REG_ADDR_W-1:0]             squash_rd,
  output wb_pend_t                          head,
  output logic [$clog2(DEPTH+1)-1:0]        count,
  output logic [DEPTH-1:0]                  ent_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]       ent_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_pend_t [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  // Popped slots drop their valid bit so the flat view only shows live entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && (r_mem[i].rd == squash_rd)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      if (pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
      end
      if (push) begin
        r_mem[r_wr_ptr] <= wb_pend_t'{valid: 1'b1, rd: push_rd, data: push_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    assign ent_valid[gi]                           = r_mem[gi].valid;
    assign ent_rd[gi*REG_ADDR_W +: REG_ADDR_W]     = r_mem[gi].rd;
  end

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_port_arbiter - core writeback vs. MUL/DIV register-file arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_port_arbiter #(
  parameter int XLEN     = wb_arb_pkg::XLEN,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              core_we,
  input  logic [wb_arb_pkg::REG_ADDR_W-1:0] core_rd,
  input  logic [XLEN-1:0]                   core_wdata,
  input  logic                              mdu_valid,
  input  logic [wb_arb_pkg::REG_ADDR_W-1:0] mdu_rd,
  input  logic [XLEN-1:0]                   mdu_wdata,
  output logic                              mdu_ready,
  output logic                              rf_we,
  output logic [wb_arb_pkg::REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]                   rf_wdata,
  output logic                              core_stall,
  input  logic [wb_arb_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [wb_arb_pkg::REG_ADDR_W-1:0] rs2_addr,
  output logic                              raw_hazard
);

  import wb_arb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);
  localparam logic [AGE_W-1:0] c_age_max   = AGE_W'(MAX_WAIT);

  arb_state_t                  r_state;
  arb_state_t                  w_state_next;
  logic [AGE_W-1:0]            r_age;
  logic [AGE_W-1:0]            w_age_next;
  logic                        r_mdu_ready;
  wb_pend_t                    w_head;
  logic [CNT_W-1:0]            w_count;
  logic [CNT_W-1:0]            w_count_next;
  logic [DEPTH-1:0]            w_ent_valid;
  logic [DEPTH*REG_ADDR_W-1:0] w_ent_rd;
  logic [DEPTH-1:0]            w_hit;
  logic                        w_stall;
  logic                        w_core_commit;
  logic                        w_accept;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_fifo_empty;

  assign w_stall       = (r_state == ARB_STALL);
  assign w_core_commit = core_we && (core_rd != '0) && !w_stall;
  assign w_accept      = mdu_valid && r_mdu_ready;
  // A same-cycle core write to the same rd is younger, so the MDU result is dropped.
  assign w_push        = w_accept && (mdu_rd != '0) &&
                         !(w_core_commit && (core_rd == mdu_rd));
  assign w_fifo_empty  = (w_count == '0);
  assign w_pop         = !w_core_commit && !w_fifo_empty;

  wb_pend_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_rd   (mdu_rd),
    .push_data (mdu_wdata),
    .pop       (w_pop),
    .squash_en (w_core_commit),
    .squash_rd (core_rd),
    .head      (w_head),
    .count     (w_count),
    .ent_valid (w_ent_valid),
    .ent_rd    (w_ent_rd)
  );

  always_comb begin
    w_count_next = w_count;
    if (w_push && !w_pop) begin
      w_count_next = w_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = w_count - CNT_W'(1);
    end
  end

  // An invalid head that is not popped holds its age; only a live result ages.
  always_comb begin
    w_age_next = r_age;
    if (w_pop || w_fifo_empty) begin
      w_age_next = '0;
    end else if (w_head.valid && (r_age != c_age_max)) begin
      w_age_next = r_age + AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age       <= '0;
      r_mdu_ready <= 1'b1;
    end else begin
      r_age       <= w_age_next;
      r_mdu_ready <= (w_count_next < c_depth_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if ((w_count_next == c_depth_cnt) || (w_age_next >= c_age_max)) begin
          w_state_next = ARB_STALL;
        end
      end
      ARB_STALL: w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    core_stall = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    if (!rst) begin
      core_stall = w_stall;
      if (w_core_commit) begin
        rf_we    = 1'b1;
        rf_waddr = core_rd;
        rf_wdata = core_wdata;
      end else if (w_pop && w_head.valid) begin
        rf_we    = 1'b1;
        rf_waddr = w_head.rd;
        rf_wdata = w_head.data;
      end
    end
  end

  assign mdu_ready = r_mdu_ready && !rst;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
    logic [REG_ADDR_W-1:0] w_rd;
    assign w_rd      = w_ent_rd[gi*REG_ADDR_W +: REG_ADDR_W];
    assign w_hit[gi] = w_ent_valid[gi] && (w_rd != '0) &&
                       ((w_rd == rs1_addr) || (w_rd == rs2_addr));
  end

  assign raw_hazard = !rst && (|w_hit);

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_wb_port_arbiter - scoreboard bench for wb_port_arbiter            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        core_stall;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        raw_hazard;

  wb_port_arbiter #(
    .XLEN     (32),
    .DEPTH    (2),
    .MAX_WAIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_we    (core_we),
    .core_rd    (core_rd),
    .core_wdata (core_wdata),
    .mdu_valid  (mdu_valid),
    .mdu_rd     (mdu_rd),
    .mdu_wdata  (mdu_wdata),
    .mdu_ready  (mdu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .core_stall (core_stall),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .raw_hazard (raw_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  cyc_n    = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Every register-file write must match the next queued expectation, in its cycle.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_write: got x%0d=%h, required no write (cycle %0d)",
                 rf_waddr, rf_wdata, cyc_n);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 32'(cyc_n), 32'(e.cyc));
        check("write_addr", {27'd0, rf_waddr}, {27'd0, e.a});
        check("write_data", rf_wdata, e.d);
      end
    end else if ((exp_q.size() != 0) && (exp_q[0].cyc <= cyc_n)) begin
      e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("FAIL missing_write: got no write, required x%0d=%h (cycle %0d)", e.a, e.d, cyc_n);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet();
    core_we    = 1'b0;
    core_rd    = 5'd0;
    core_wdata = 32'd0;
    mdu_valid  = 1'b0;
    mdu_rd     = 5'd0;
    mdu_wdata  = 32'd0;
  endtask

  task automatic core_wr(input logic [4:0] rd, input logic [31:0] d);
    core_we    = 1'b1;
    core_rd    = rd;
    core_wdata = d;
  endtask

  task automatic mdu_res(input logic [4:0] rd, input logic [31:0] d);
    mdu_valid = 1'b1;
    mdu_rd    = rd;
    mdu_wdata = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.cyc = cyc_n;
    e.a   = a;
    e.d   = d;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outs();
    check("rst_rf_we",      {31'd0, rf_we},      32'd0);
    check("rst_rf_waddr",   {27'd0, rf_waddr},   32'd0);
    check("rst_rf_wdata",   rf_wdata,            32'd0);
    check("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check("rst_mdu_ready",  {31'd0, mdu_ready},  32'd0);
    check("rst_raw_hazard", {31'd0, raw_hazard}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    quiet();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    rst      = 1'b1;

    // Reset with live inputs: every output held at zero.
    next_cycle(); core_wr(5'd5, 32'h0000_1234); mdu_res(5'd6, 32'h0000_5678); rs1_addr = 5'd6;
    sample(); check_reset_outs();
    next_cycle(); sample(); check_reset_outs();
    next_cycle(); rst = 1'b0; quiet(); rs1_addr = 5'd0;
    sample();
    check("post_rst_mdu_ready", {31'd0, mdu_ready},  32'd1);
    check("post_rst_stall",     {31'd0, core_stall}, 32'd0);

    // Core-only write and a write to x0.
    next_cycle(); core_wr(5'd5, 32'hAAAA_AAAA); expect_wr(5'd5, 32'hAAAA_AAAA);
    sample(); check("core_only_stall", {31'd0, core_stall}, 32'd0);
    next_cycle(); core_wr(5'd0, 32'hDEAD_BEEF);
    sample(); check("x0_no_we", {31'd0, rf_we}, 32'd0);

    // Idle drain, one cycle after acceptance, hazard visible only while pending.
    next_cycle(); quiet(); mdu_res(5'd7, 32'hBBBB_BBBB); rs1_addr = 5'd7;
    sample();
    check("drain_ready",      {31'd0, mdu_ready},  32'd1);
    check("drain_haz_before", {31'd0, raw_hazard}, 32'd0);
    next_cycle(); quiet(); expect_wr(5'd7, 32'hBBBB_BBBB);
    sample(); check("drain_haz_pending", {31'd0, raw_hazard}, 32'd1);
    next_cycle();
    sample(); check("drain_haz_after", {31'd0, raw_hazard}, 32'd0);
    rs1_addr = 5'd0;

    // Forced stall by age under continuous core writes.
    next_cycle(); quiet(); mdu_res(5'd9, 32'h1111_1111); core_wr(5'd3, 32'h3000_0001);
    expect_wr(5'd3, 32'h3000_0001);
    sample(); check("age_accept_stall", {31'd0, core_stall}, 32'd0);
    for (int k = 2; k <= 5; k++) begin
      next_cycle(); quiet(); core_wr(5'd3, 32'h3000_0000 + 32'(k));
      expect_wr(5'd3, 32'h3000_0000 + 32'(k));
      sample(); check("age_wait_no_stall", {31'd0, core_stall}, 32'd0);
    end
    next_cycle(); core_wr(5'd3, 32'h3000_0006); expect_wr(5'd9, 32'h1111_1111);
    sample(); check("age_stall", {31'd0, core_stall}, 32'd1);
    next_cycle(); core_wr(5'd3, 32'h3000_0007); expect_wr(5'd3, 32'h3000_0007);
    sample(); check("age_stall_one_cycle", {31'd0, core_stall}, 32'd0);

    // Full FIFO: ready drops, stall drains head, ready returns.
    next_cycle(); quiet(); mdu_res(5'd10, 32'hA1A1_A1A1); core_wr(5'd3, 32'h4000_0001);
    expect_wr(5'd3, 32'h4000_0001);
    sample(); check("full_ready_0", {31'd0, mdu_ready}, 32'd1);
    next_cycle(); quiet(); mdu_res(5'd11, 32'hA2A2_A2A2); core_wr(5'd3, 32'h4000_0002);
    expect_wr(5'd3, 32'h4000_0002);
    sample();
    check("full_ready_1", {31'd0, mdu_ready},  32'd1);
    check("full_pre_stall", {31'd0, core_stall}, 32'd0);
    next_cycle(); quiet(); core_wr(5'd3, 32'h4000_0003); expect_wr(5'd10, 32'hA1A1_A1A1);
    sample();
    check("full_not_ready", {31'd0, mdu_ready},  32'd0);
    check("full_stall",     {31'd0, core_stall}, 32'd1);
    next_cycle(); quiet(); core_wr(5'd3, 32'h4000_0004); expect_wr(5'd3, 32'h4000_0004);
    sample();
    check("full_ready_back", {31'd0, mdu_ready},  32'd1);
    check("full_post_stall", {31'd0, core_stall}, 32'd0);
    next_cycle(); quiet(); expect_wr(5'd11, 32'hA2A2_A2A2);
    sample();

    // WAW squash: pending x4 is overwritten by the core and popped silently.
    next_cycle(); quiet(); mdu_res(5'd4, 32'h2222_2222); rs2_addr = 5'd4;
    sample();
    next_cycle(); quiet(); core_wr(5'd4, 32'h3333_3333); expect_wr(5'd4, 32'h3333_3333);
    sample(); check("waw_haz_pending", {31'd0, raw_hazard}, 32'd1);
    next_cycle(); quiet();
    sample();
    check("waw_haz_squashed", {31'd0, raw_hazard}, 32'd0);
    check("waw_no_write",     {31'd0, rf_we},      32'd0);
    check("waw_ready",        {31'd0, mdu_ready},  32'd1);

    // Same-cycle MDU result to the core's rd is dropped.
    next_cycle(); quiet(); rs2_addr = 5'd0; rs1_addr = 5'd6;
    mdu_res(5'd6, 32'h5555_5555); core_wr(5'd6, 32'h6666_6666); expect_wr(5'd6, 32'h6666_6666);
    sample();
    next_cycle(); quiet();
    sample();
    check("drop_no_hazard", {31'd0, raw_hazard}, 32'd0);
    check("drop_no_write",  {31'd0, rf_we},      32'd0);

    // Reset with two pending entries (arbiter in STALL) flushes everything.
    next_cycle(); quiet(); rs1_addr = 5'd0; mdu_res(5'd12, 32'hC1C1_C1C1);
    core_wr(5'd3, 32'h7000_0001); expect_wr(5'd3, 32'h7000_0001);
    sample();
    next_cycle(); quiet(); mdu_res(5'd13, 32'hC2C2_C2C2);
    core_wr(5'd3, 32'h7000_0002); expect_wr(5'd3, 32'h7000_0002);
    sample();
    next_cycle(); quiet(); rst = 1'b1; core_wr(5'd3, 32'h7000_0003);
    rs1_addr = 5'd12; rs2_addr = 5'd13;
    sample(); check_reset_outs();
    next_cycle();
    sample(); check_reset_outs();
    next_cycle(); rst = 1'b0; quiet();
    sample();
    check("mid_rst_ready",  {31'd0, mdu_ready},  32'd1);
    check("mid_rst_hazard", {31'd0, raw_hazard}, 32'd0);
    check("mid_rst_stall",  {31'd0, core_stall}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      sample();
      check("mid_rst_no_stall", {31'd0, core_stall}, 32'd0);
      check("mid_rst_no_we",    {31'd0, rf_we},      32'd0);
    end

    next_cycle();
    sample();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
